// File: rtl/apb_cfg_regs_pkg.sv
// Shared types and sizing helpers for the apb_cfg_regs register bank.
package apb_cfg_regs_pkg;

  localparam int WAIT_CNT_W = 4;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_e;

  function automatic int strb_width(input int data_width);
    return data_width / 8;
  endfunction

  // A single register still needs a 1-bit index to keep the decode uniform.
  function automatic int idx_width(input int n_regs);
    return (n_regs > 1) ? $clog2(n_regs) : 1;
  endfunction

  function automatic int align_shift(input int data_width);
    return $clog2(data_width / 8);
  endfunction

endpackage

// File: rtl/apb_cfg_regs_access.sv
// APB access-phase sequencer: wait-state counter, pready generation and a
// one-cycle commit strobe for legal writes.
module apb_cfg_regs_access
  import apb_cfg_regs_pkg::*;
#(
  parameter int WAIT_CYCLES = 0
) (
  input  logic pclk_i,
  input  logic preset_ni,
  input  logic access_i,
  input  logic pwrite_i,
  input  logic err_i,
  output logic pready_o,
  output logic commit_o
);

  localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD =
    (WAIT_CYCLES > 0) ? WAIT_CNT_W'(WAIT_CYCLES - 1) : '0;

  state_e                state_q, state_d;
  logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;
  logic                  ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ready   = 1'b0;
    case (state_q)
      IDLE: begin
        if (access_i) begin
          if (WAIT_CYCLES == 0) begin
            ready = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = WAIT_LOAD;
          end
        end
      end
      WAIT: begin
        // Losing psel/penable mid-wait abandons the transfer without a commit.
        if (!access_i) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          ready   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge pclk_i or negedge preset_ni) begin
    if (!preset_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign pready_o = ready;
  assign commit_o = ready & pwrite_i & ~err_i;

endmodule

// File: rtl/apb_cfg_regs.sv
// Parametrised APB configuration register bank with wait states, RO masking,
// hardware update port and write pulses. Optional lock: APB_CFG_REGS_LOCK_EN.
module apb_cfg_regs
  import apb_cfg_regs_pkg::*;
#(
  parameter int                    N_REGS      = 4,
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    ADDR_WIDTH  = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
  parameter logic [N_REGS-1:0]     RO_MASK     = '0,
  parameter int                    WAIT_CYCLES = 0
`ifdef APB_CFG_REGS_LOCK_EN
  ,
  parameter logic [N_REGS-1:0]     LOCK_MASK   = '0
`endif
) (
  input  logic                                pclk_i,
  input  logic                                preset_ni,
  input  logic [ADDR_WIDTH-1:0]               paddr_i,
  input  logic [2:0]                          pprot_i,
  input  logic                                psel_i,
  input  logic                                penable_i,
  input  logic                                pwrite_i,
  input  logic [DATA_WIDTH-1:0]               pwdata_i,
  input  logic [DATA_WIDTH/8-1:0]             pstrb_i,
  output logic                                pready_o,
  output logic [DATA_WIDTH-1:0]               prdata_o,
  output logic                                pslverr_o,
`ifdef APB_CFG_REGS_LOCK_EN
  input  logic                                lock_i,
`endif
  input  logic [N_REGS-1:0][DATA_WIDTH-1:0]   init_i,
  input  logic [N_REGS-1:0]                   hw_we_i,
  input  logic [N_REGS-1:0][DATA_WIDTH-1:0]   hw_wdata_i,
  output logic [N_REGS-1:0][DATA_WIDTH-1:0]   q_o,
  output logic [N_REGS-1:0]                   wr_pulse_o
);

  localparam int                    STRB_W     = strb_width(DATA_WIDTH);
  localparam int                    IDX_W      = idx_width(N_REGS);
  localparam int                    SH         = align_shift(DATA_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(STRB_W - 1);
  localparam logic [ADDR_WIDTH-1:0] N_REGS_A   = ADDR_WIDTH'(N_REGS);

  if (N_REGS < 1) begin : g_chk_n_regs
    $fatal(1, "apb_cfg_regs: N_REGS must be >= 1");
  end
  if (DATA_WIDTH != 8 && DATA_WIDTH != 16 && DATA_WIDTH != 32) begin : g_chk_width
    $fatal(1, "apb_cfg_regs: DATA_WIDTH must be 8, 16 or 32");
  end
  if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_chk_wait
    $fatal(1, "apb_cfg_regs: WAIT_CYCLES must be 0..15");
  end
  if ((BASE_ADDR & ALIGN_MASK) != '0) begin : g_chk_base
    $fatal(1, "apb_cfg_regs: BASE_ADDR must be aligned to the data width");
  end

  logic [N_REGS-1:0][DATA_WIDTH-1:0] reg_q, reg_d;
  logic [N_REGS-1:0]                 wr_pulse_q, wr_pulse_d;

  logic [ADDR_WIDTH-1:0] offset, idx_full;
  logic [IDX_W-1:0]      idx;
  logic                  below_base, out_of_range, misaligned;
  logic                  ro_hit, lock_hit, err;
  logic                  commit;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  unused_pprot;

  assign unused_pprot = ^pprot_i;

  // Address decode and error classification
  always_comb begin
    offset       = paddr_i - BASE_ADDR;
    idx_full     = offset >> SH;
    idx          = idx_full[IDX_W-1:0];
    below_base   = paddr_i < BASE_ADDR;
    out_of_range = idx_full >= N_REGS_A;
    misaligned   = (offset & ALIGN_MASK) != '0;
    ro_hit       = 1'b0;
    lock_hit     = 1'b0;
    for (int i = 0; i < N_REGS; i++) begin
      if (idx == IDX_W'(i)) begin
        ro_hit = RO_MASK[i];
`ifdef APB_CFG_REGS_LOCK_EN
        lock_hit = lock_i & LOCK_MASK[i];
`endif
      end
    end
    err = below_base | out_of_range | misaligned | (pwrite_i & (ro_hit | lock_hit));
  end

  apb_cfg_regs_access #(
    .WAIT_CYCLES (WAIT_CYCLES)
  ) u_access (
    .pclk_i    (pclk_i),
    .preset_ni (preset_ni),
    .access_i  (psel_i & penable_i),
    .pwrite_i  (pwrite_i),
    .err_i     (err),
    .pready_o  (pready_o),
    .commit_o  (commit)
  );

  always_comb begin
    rd_data = '0;
    if (pready_o && !pwrite_i && !err) begin
      for (int i = 0; i < N_REGS; i++) begin
        if (idx == IDX_W'(i)) rd_data = reg_q[i];
      end
    end
  end

  assign prdata_o  = rd_data;
  assign pslverr_o = pready_o & err;

  // APB commit overrides a same-edge hardware update; unstrobed bytes keep reg_q.
  always_comb begin
    reg_d      = reg_q;
    wr_pulse_d = '0;
    for (int i = 0; i < N_REGS; i++) begin
      if (hw_we_i[i]) reg_d[i] = hw_wdata_i[i];
      if (commit && idx == IDX_W'(i)) begin
        wr_pulse_d[i] = 1'b1;
        for (int b = 0; b < STRB_W; b++) begin
          reg_d[i][8*b +: 8] = pstrb_i[b] ? pwdata_i[8*b +: 8] : reg_q[i][8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge pclk_i or negedge preset_ni) begin
    if (!preset_ni) begin
      reg_q      <= init_i;
      wr_pulse_q <= '0;
    end else begin
      reg_q      <= reg_d;
      wr_pulse_q <= wr_pulse_d;
    end
  end

  assign q_o        = reg_q;
  assign wr_pulse_o = wr_pulse_q;

endmodule
